// File: rtl/dm_sized.sv
// -----------------------------------------------------------------------------
// dm_sized -- byte-addressed data memory for the multi-cycle MIPS datapath.
//
// Supports byte/half/word loads (sign- or zero-extended) and stores with
// byte-lane write merging. A req/done handshake with a programmable access
// latency (LATENCY cycles from accepted req to done) models slower memories.
//
// Parameters
//   ADDR_W   word-address bits; array depth is 2**ADDR_W words of 32 bits
//   LATENCY  cycles from accepted req to done (1..15)
//
// Ports
//   clk    in   clock, all state updates on posedge
//   rst    in   synchronous reset, active-high
//   req    in   access request, sampled only while ready=1
//   we     in   1=store, 0=load
//   size   in   00=byte, 01=half, 10=word, 11=treated as word
//   sext   in   loads: 1=sign-extend, 0=zero-extend byte/half
//   addr   in   byte address ([ADDR_W+1:2] word index, [1:0] byte offset)
//   wdata  in   right-justified store data
//   ready  out  1 while idle: a new req is accepted this cycle
//   done   out  one-cycle completion pulse; rdata valid on loads
//   rdata  out  extended load result, held until the next load completes
//   err    out  misaligned-access flag, valid with done
//
// Build option
//   DM_MISALIGN_CHK_EN  when defined, misaligned accesses complete the
//                       handshake but write nothing / leave rdata unchanged
//                       and raise err during the done cycle. When undefined,
//                       err is always 0 and low offset bits are truncated.
//
// The word array itself is not reset.
// -----------------------------------------------------------------------------
module dm_sized #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t             state_r;
  state_t             state_n;
  logic [3:0]         cnt_r;
  logic               we_r;
  logic [1:0]         size_r;
  logic               sext_r;
  logic [ADDR_W+1:0]  addr_r;
  logic [31:0]        wdata_r;
  logic               ready_r;
  logic               done_r;
  logic [31:0]        rdata_r;
  logic               err_r;
  logic [31:0]        mem_r [0:(2**ADDR_W)-1];

  logic               final_s;
  logic               blk_s;
  logic               wr_en_s;
  logic [3:0]         be_s;
  logic [31:0]        lane_s;
  logic [31:0]        word_s;
  logic [ADDR_W-1:0]  idx_s;

  // Byte enables for a store; half uses off[1] only, word writes all lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it could occupy.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   lane_data = {4{wd[7:0]}};
      2'b01:   lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] wrd, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sx);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = wrd >> {off, 3'b000};
    half    = off[1] ? wrd[31:16] : wrd[15:0];
    case (sz)
      2'b00:   load_ext = {{24{sx & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sx & half[15]}}, half};
      default: load_ext = wrd;
    endcase
  endfunction

  assign idx_s   = addr_r[ADDR_W+1:2];
  assign word_s  = mem_r[idx_s];
  assign be_s    = byte_en(size_r, addr_r[1:0]);
  assign lane_s  = lane_data(size_r, wdata_r);
  assign final_s = (state_r == ST_BUSY) && (cnt_r == CNT_LAST);

`ifdef DM_MISALIGN_CHK_EN
  logic mis_s;
  assign mis_s = ((size_r == 2'b01) && addr_r[0]) || (size_r[1] && (addr_r[1:0] != 2'b00));
  assign blk_s = mis_s;
`else
  assign blk_s = 1'b0;
`endif

  // A reset on the final BUSY edge cancels the store.
  assign wr_en_s = final_s && we_r && !blk_s && !rst;

  // Next-state logic for the handshake FSM.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) state_n = ST_BUSY;
        else     state_n = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_r == CNT_LAST) state_n = ST_DONE;
        else                   state_n = ST_BUSY;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state, request capture, latency counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sext_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      ready_r <= (state_n == ST_IDLE);
      done_r  <= (state_n == ST_DONE);
      if ((state_r == ST_IDLE) && req) begin
        we_r    <= we;
        size_r  <= size;
        sext_r  <= sext;
        addr_r  <= addr;
        wdata_r <= wdata;
        cnt_r   <= 4'd0;
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r + 4'd1;
      end
      if (final_s && !we_r && !blk_s) begin
        rdata_r <= load_ext(word_s, size_r, addr_r[1:0], sext_r);
      end
`ifdef DM_MISALIGN_CHK_EN
      err_r <= final_s && mis_s;
`else
      err_r <= 1'b0;
`endif
    end
  end

  // Byte-lane write into the (unreset) word array.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) mem_r[idx_s][8*b +: 8] <= lane_s[8*b +: 8];
      end
    end
  end

  assign ready = ready_r;
  assign done  = done_r;
  assign rdata = rdata_r;
  assign err   = err_r;

endmodule

// File: tb/tb_dm_sized.sv
module tb_dm_sized;

  logic        clk = 1'b0;
  logic        rst, req, we, sext;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        ready, done, err;
  logic [31:0] rdata;

  logic        rst4, req4, we4, sext4;
  logic [1:0]  size4;
  logic [11:0] addr4;
  logic [31:0] wdata4;
  logic        ready4, done4, err4;
  logic [31:0] rdata4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_sized #(.ADDR_W(10), .LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .err(err)
  );

  dm_sized #(.ADDR_W(10), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst4), .req(req4), .we(we4), .size(size4), .sext(sext4),
    .addr(addr4), .wdata(wdata4), .ready(ready4), .done(done4), .rdata(rdata4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=1 instance; returns edges to done, rdata and err at done.
  task automatic acc(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [11:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; addr = 12'hFFF; wdata = 32'hDEADBEEF;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    er = err;
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          dcnt, rcnt, t;
  int          dat [3];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; sext = 1'b0; size = 2'b00; addr = 12'h000; wdata = 32'd0;
    rst4 = 1'b1; req4 = 1'b0; we4 = 1'b0; sext4 = 1'b0; size4 = 2'b00; addr4 = 12'h000; wdata4 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_rdata", rdata,          32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    @(negedge clk); rst = 1'b0; rst4 = 1'b0;

    acc(1'b1, 2'b10, 1'b0, 12'h010, 32'h12345678, lat, rd, er);
    check("sw_lat", lat, 32'd1);
    check("sw_rdata_held", rd, 32'd0);
    acc(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, lat, rd, er);
    check("lw_lat", lat, 32'd1);
    check("lw_0x10", rd, 32'h12345678);

    acc(1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AB, lat, rd, er);
    acc(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, lat, rd, er);
    check("sb_merge", rd, 32'h1234AB78);
    acc(1'b0, 2'b00, 1'b1, 12'h011, 32'd0, lat, rd, er);
    check("lb_0x11", rd, 32'hFFFFFFAB);
    acc(1'b0, 2'b00, 1'b0, 12'h011, 32'd0, lat, rd, er);
    check("lbu_0x11", rd, 32'h000000AB);

    acc(1'b1, 2'b01, 1'b0, 12'h012, 32'h00008001, lat, rd, er);
    acc(1'b0, 2'b01, 1'b1, 12'h012, 32'd0, lat, rd, er);
    check("lh_0x12", rd, 32'hFFFF8001);
    acc(1'b0, 2'b01, 1'b0, 12'h012, 32'd0, lat, rd, er);
    check("lhu_0x12", rd, 32'h00008001);
    acc(1'b0, 2'b10, 1'b1, 12'h010, 32'd0, lat, rd, er);
    check("sh_merge", rd, 32'h8001AB78);
    acc(1'b0, 2'b00, 1'b1, 12'h013, 32'd0, lat, rd, er);
    check("lb_0x13", rd, 32'hFFFFFF80);
    acc(1'b0, 2'b00, 1'b0, 12'h010, 32'd0, lat, rd, er);
    check("lbu_0x10", rd, 32'h00000078);

    acc(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h0BADF00D, lat, rd, er);
    acc(1'b0, 2'b10, 1'b0, 12'hFFC, 32'd0, lat, rd, er);
    check("lw_top", rd, 32'h0BADF00D);

    // misaligned word store and word load
    acc(1'b1, 2'b10, 1'b0, 12'h013, 32'hCAFEF00D, lat, rd, er);
    check("mis_sw_lat", lat, 32'd1);
`ifdef DM_MISALIGN_CHK_EN
    check("mis_sw_err", {31'd0, er}, 32'd1);
`else
    check("mis_sw_err", {31'd0, er}, 32'd0);
`endif
    check("mis_sw_rdata_held", rd, 32'h0BADF00D);
    acc(1'b0, 2'b10, 1'b0, 12'h011, 32'd0, lat, rd, er);
`ifdef DM_MISALIGN_CHK_EN
    check("mis_lw_err", {31'd0, er}, 32'd1);
    check("mis_lw_rdata", rd, 32'h0BADF00D);
`else
    check("mis_lw_err", {31'd0, er}, 32'd0);
    check("mis_lw_rdata", rd, 32'hCAFEF00D);
`endif
    acc(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, lat, rd, er);
    check("al_lw_err", {31'd0, er}, 32'd0);
    check("err_low_after", {31'd0, err}, 32'd0);
`ifdef DM_MISALIGN_CHK_EN
    check("mis_mem_0x10", rd, 32'h8001AB78);
`else
    check("mis_mem_0x10", rd, 32'hCAFEF00D);
`endif

    // LATENCY=4: continuous req, stores of A5A5A5A5 to 0x20
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; size4 = 2'b10; addr4 = 12'h020; wdata4 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    dcnt = 0; rcnt = 0;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      if (done4) begin
        if (dcnt < 3) dat[dcnt] = e;
        dcnt++;
      end
      if (ready4) rcnt++;
    end
    @(negedge clk); req4 = 1'b0;
    check("l4_done_cnt", dcnt, 32'd3);
    check("l4_ready_cnt", rcnt, 32'd3);
    check("l4_done0", dat[0], 32'd4);
    check("l4_done1", dat[1], 32'd10);
    check("l4_done2", dat[2], 32'd16);

    // store aborted by reset on its final BUSY edge
    @(posedge clk); #1;
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; size4 = 2'b10; addr4 = 12'h020; wdata4 = 32'h22222222;
    @(posedge clk); #1;
    req4 = 1'b0;
    check("l4_busy_ready", {31'd0, ready4}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst4 = 1'b1;
    @(posedge clk); #1;
    check("l4_rst_done", {31'd0, done4}, 32'd0);
    check("l4_rst_ready", {31'd0, ready4}, 32'd1);
    @(negedge clk); rst4 = 1'b0;
    dcnt = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      if (done4) dcnt++;
    end
    check("l4_no_done", dcnt, 32'd0);

    @(negedge clk);
    req4 = 1'b1; we4 = 1'b0; size4 = 2'b10; addr4 = 12'h020;
    @(posedge clk); #1;
    req4 = 1'b0;
    t = 0;
    while (!done4 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("l4_lw_lat", t, 32'd4);
    check("l4_store_lost", rdata4, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
